// File: rtl/pipe5_mem_arbiter_if.sv
// Bundle of fetch (i_*), load/store (d_*) and shared bus (b_*) signals around the pipe5 memory arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and bus adapter's view.
`timescale 1ns/1ps

interface pipe5_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_ren;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_busy;

    logic                  d_ren;
    logic                  d_wen;
    logic [DATA_W/8-1:0]   d_byte_en;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_busy;

    logic                  b_ren;
    logic                  b_wen;
    logic [DATA_W/8-1:0]   b_byte_en;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_wdata;
    logic [DATA_W-1:0]     b_rdata;
    logic                  b_busy;

    modport master (
        input  i_ren, i_addr,
        output i_rdata, i_busy,
        input  d_ren, d_wen, d_byte_en, d_addr, d_wdata,
        output d_rdata, d_busy,
        output b_ren, b_wen, b_byte_en, b_addr, b_wdata,
        input  b_rdata, b_busy
    );

    modport slave (
        output i_ren, i_addr,
        input  i_rdata, i_busy,
        output d_ren, d_wen, d_byte_en, d_addr, d_wdata,
        input  d_rdata, d_busy,
        input  b_ren, b_wen, b_byte_en, b_addr, b_wdata,
        output b_rdata, b_busy
    );
endinterface

// File: rtl/pipe5_mem_arbiter.sv
// Shares one memory bus port between pipe5 fetch (I) and load/store (D); D has priority.
// Define ARB_FAIR_EN to force an I grant after MAX_DSTREAK consecutive D grants with I waiting.
`timescale 1ns/1ps

module pipe5_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
`ifdef ARB_FAIR_EN
    ,
    parameter int MAX_DSTREAK = 4
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe5_mem_arbiter_if.master bus_if
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        I_GNT,
        D_GNT
    } state_e;

    state_e              state_q;
    logic                bRen_q;
    logic                bWen_q;
    logic [BE_W-1:0]     bByteEn_q;
    logic [ADDR_W-1:0]   bAddr_q;
    logic [DATA_W-1:0]   bWdata_q;
    logic                stale_q;

    logic dReq;
    logic ownerReq;
    logic busDone;
    logic iDone;
    logic dDone;
    logic grantI;
    logic grantD;

    assign dReq     = bus_if.d_ren | bus_if.d_wen;
    assign ownerReq = (state_q == I_GNT) ? bus_if.i_ren : dReq;
    assign busDone  = (state_q != IDLE) && !bus_if.b_busy;

    // A withdrawn transaction still completes on the bus but never releases its requester.
    assign iDone = busDone && (state_q == I_GNT) && !stale_q;
    assign dDone = busDone && (state_q == D_GNT) && !stale_q;

    assign bus_if.i_busy  = bus_if.i_ren && !iDone;
    assign bus_if.d_busy  = dReq && !dDone;
    assign bus_if.i_rdata = iDone ? bus_if.b_rdata : '0;
    assign bus_if.d_rdata = dDone ? bus_if.b_rdata : '0;

    assign bus_if.b_ren     = bRen_q;
    assign bus_if.b_wen     = bWen_q;
    assign bus_if.b_byte_en = bByteEn_q;
    assign bus_if.b_addr    = bAddr_q;
    assign bus_if.b_wdata   = bWdata_q;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);

    logic [STREAK_W-1:0] streak_q;
    logic                forceI;

    assign forceI = bus_if.i_ren && (streak_q >= STREAK_W'(MAX_DSTREAK));
    assign grantD = dReq && !forceI;

    // Streak only advances while I is actually waiting behind D.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else if (state_q == IDLE) begin
            if (grantD) begin
                if (!bus_if.i_ren) begin
                    streak_q <= '0;
                end else if (streak_q < STREAK_W'(MAX_DSTREAK)) begin
                    streak_q <= streak_q + 1'b1;
                end
            end else if (grantI) begin
                streak_q <= '0;
            end
        end
    end
`else
    assign grantD = dReq;
`endif

    assign grantI = bus_if.i_ren && !grantD;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bRen_q    <= 1'b0;
            bWen_q    <= 1'b0;
            bByteEn_q <= '0;
            bAddr_q   <= '0;
            bWdata_q  <= '0;
            stale_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stale_q <= 1'b0;
                    if (grantD) begin
                        state_q   <= D_GNT;
                        bRen_q    <= bus_if.d_ren;
                        bWen_q    <= bus_if.d_wen;
                        bByteEn_q <= bus_if.d_byte_en;
                        bAddr_q   <= bus_if.d_addr;
                        bWdata_q  <= bus_if.d_wdata;
                    end else if (grantI) begin
                        state_q   <= I_GNT;
                        bRen_q    <= 1'b1;
                        bWen_q    <= 1'b0;
                        bByteEn_q <= '1;
                        bAddr_q   <= bus_if.i_addr;
                        bWdata_q  <= '0;
                    end
                end
                I_GNT, D_GNT: begin
                    if (!bus_if.b_busy) begin
                        state_q <= IDLE;
                        bRen_q  <= 1'b0;
                        bWen_q  <= 1'b0;
                        stale_q <= 1'b0;
                    end else if (!ownerReq) begin
                        stale_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bRen_q  <= 1'b0;
                    bWen_q  <= 1'b0;
                    stale_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe5_mem_arbiter.sv
// Directed self-checking bench for pipe5_mem_arbiter; expectations are hand-derived cycle by cycle.
`timescale 1ns/1ps

module tb_pipe5_mem_arbiter;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    pipe5_mem_arbiter_if bus ();

    pipe5_mem_arbiter dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic        iRen,
        input logic [31:0] iAddr,
        input logic        dRen,
        input logic        dWen,
        input logic [3:0]  dByteEn,
        input logic [31:0] dAddr,
        input logic [31:0] dWdata,
        input logic        bBusy,
        input logic [31:0] bRdata
    );
        bus.i_ren     = iRen;
        bus.i_addr    = iAddr;
        bus.d_ren     = dRen;
        bus.d_wen     = dWen;
        bus.d_byte_en = dByteEn;
        bus.d_addr    = dAddr;
        bus.d_wdata   = dWdata;
        bus.b_busy    = bBusy;
        bus.b_rdata   = bRdata;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [9:0] grantSeq;
    logic [9:0] expSeq;
    int         iGrants;
    int         dGrants;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        advance();
        advance();
        rst = 1'b0;

        // Reset state
        sample();
        checkOutput("rst_b_ren",  bus.b_ren,  0);
        checkOutput("rst_b_wen",  bus.b_wen,  0);
        checkOutput("rst_b_addr", bus.b_addr, 0);
        checkOutput("rst_i_busy", bus.i_busy, 0);
        checkOutput("rst_d_busy", bus.d_busy, 0);
        advance();

        // Lone fetch, zero-wait bus
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 32'h11223344);
        sample();
        checkOutput("t1_req_i_busy", bus.i_busy, 1);
        checkOutput("t1_req_b_ren",  bus.b_ren,  0);
        advance();
        sample();
        checkOutput("t1_b_ren",     bus.b_ren,     1);
        checkOutput("t1_b_addr",    bus.b_addr,    32'h100);
        checkOutput("t1_b_byte_en", bus.b_byte_en, 4'hF);
        checkOutput("t1_i_busy",    bus.i_busy,    0);
        checkOutput("t1_i_rdata",   bus.i_rdata,   32'h11223344);
        advance();
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h11223344);
        sample();
        checkOutput("t1_after_b_ren",   bus.b_ren,   0);
        checkOutput("t1_after_i_rdata", bus.i_rdata, 0);
        advance();

        // Simultaneous fetch and store: D first, I two cycles after D completes
        applyStimulus(1, 32'h180, 0, 1, 4'hF, 32'h200, 32'hDEADBEEF, 0, 32'h55);
        sample();
        checkOutput("t2_req_d_busy", bus.d_busy, 1);
        checkOutput("t2_req_i_busy", bus.i_busy, 1);
        advance();
        sample();
        checkOutput("t2_d_b_wen",     bus.b_wen,     1);
        checkOutput("t2_d_b_ren",     bus.b_ren,     0);
        checkOutput("t2_d_b_addr",    bus.b_addr,    32'h200);
        checkOutput("t2_d_b_wdata",   bus.b_wdata,   32'hDEADBEEF);
        checkOutput("t2_d_b_byte_en", bus.b_byte_en, 4'hF);
        checkOutput("t2_d_d_busy",    bus.d_busy,    0);
        checkOutput("t2_d_i_busy",    bus.i_busy,    1);
        advance();
        applyStimulus(1, 32'h180, 0, 0, 4'h0, 0, 0, 0, 32'h66);
        sample();
        checkOutput("t2_bubble_i_busy", bus.i_busy, 1);
        checkOutput("t2_bubble_b_wen",  bus.b_wen,  0);
        checkOutput("t2_bubble_b_ren",  bus.b_ren,  0);
        advance();
        sample();
        checkOutput("t2_i_b_ren",   bus.b_ren,   1);
        checkOutput("t2_i_b_addr",  bus.b_addr,  32'h180);
        checkOutput("t2_i_i_busy",  bus.i_busy,  0);
        checkOutput("t2_i_i_rdata", bus.i_rdata, 32'h66);
        advance();
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        advance();

        // Load stretched by three bus wait cycles
        applyStimulus(0, 0, 1, 0, 4'h3, 32'h40, 0, 0, 0);
        sample();
        checkOutput("t3_req_d_busy", bus.d_busy, 1);
        advance();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0, 4'h3, 32'h40, 0, 1, 32'h99);
            sample();
            checkOutput("t3_wait_d_busy",    bus.d_busy,    1);
            checkOutput("t3_wait_b_ren",     bus.b_ren,     1);
            checkOutput("t3_wait_b_addr",    bus.b_addr,    32'h40);
            checkOutput("t3_wait_b_byte_en", bus.b_byte_en, 4'h3);
            checkOutput("t3_wait_d_rdata",   bus.d_rdata,   0);
            advance();
        end
        applyStimulus(0, 0, 1, 0, 4'h3, 32'h40, 0, 0, 32'hA5A5A5A5);
        sample();
        checkOutput("t3_done_d_busy",  bus.d_busy,  0);
        checkOutput("t3_done_d_rdata", bus.d_rdata, 32'hA5A5A5A5);
        checkOutput("t3_done_b_ren",   bus.b_ren,   1);
        advance();
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        sample();
        checkOutput("t3_after_b_ren", bus.b_ren, 0);
        advance();

        // Fetch withdrawn mid-transaction, then reissued to 0x104
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
        advance();
        applyStimulus(0, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0);
        sample();
        checkOutput("t4_wd_i_busy", bus.i_busy, 0);
        checkOutput("t4_wd_b_ren",  bus.b_ren,  1);
        advance();
        applyStimulus(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 0);
        sample();
        checkOutput("t4_new_i_busy", bus.i_busy, 1);
        checkOutput("t4_new_b_addr", bus.b_addr, 32'h100);
        advance();
        applyStimulus(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 32'h77);
        sample();
        checkOutput("t4_old_done_i_busy",  bus.i_busy,  1);
        checkOutput("t4_old_done_i_rdata", bus.i_rdata, 0);
        checkOutput("t4_old_done_b_ren",   bus.b_ren,   1);
        advance();
        sample();
        checkOutput("t4_bubble_b_ren",  bus.b_ren,  0);
        checkOutput("t4_bubble_i_busy", bus.i_busy, 1);
        advance();
        sample();
        checkOutput("t4_reissue_b_addr",  bus.b_addr,  32'h104);
        checkOutput("t4_reissue_b_ren",   bus.b_ren,   1);
        checkOutput("t4_reissue_i_busy",  bus.i_busy,  0);
        checkOutput("t4_reissue_i_rdata", bus.i_rdata, 32'h77);
        advance();
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        advance();

        // Reset pulsed while D owns the bus
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h80, 0, 1, 0);
        advance();
        rst = 1'b1;
        sample();
        checkOutput("t5_gnt_b_ren", bus.b_ren, 1);
        advance();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        sample();
        checkOutput("t5_b_ren",  bus.b_ren,  0);
        checkOutput("t5_b_wen",  bus.b_wen,  0);
        checkOutput("t5_b_addr", bus.b_addr, 0);
        checkOutput("t5_d_busy", bus.d_busy, 0);
        checkOutput("t5_i_busy", bus.i_busy, 0);
        advance();

        // Continuous D and I requests: grant order
`ifdef ARB_FAIR_EN
        expSeq = 10'b0000100001;
`else
        expSeq = 10'b0000000000;
`endif
        grantSeq = '0;
        iGrants  = 0;
        dGrants  = 0;
        applyStimulus(1, 32'h300, 1, 0, 4'hF, 32'h400, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            sample();
            if (bus.b_ren) begin
                if (bus.b_addr == 32'h300) begin
                    iGrants++;
                    grantSeq = {grantSeq[8:0], 1'b1};
                end else begin
                    dGrants++;
                    grantSeq = {grantSeq[8:0], 1'b0};
                end
            end
            advance();
        end
        checkOutput("t6_grant_seq",    grantSeq,          expSeq);
        checkOutput("t6_grant_total",  iGrants + dGrants, 10);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
